spi_reg_peripheral: RTL and testbench

// - SPI peripheral (mode 0, write-only) that receives 16-bit frames from an external controller and

---
 rtl/spi_reg_pkg.sv | 17 +
 rtl/spi_reg_peripheral_if.sv | 9 +
 rtl/spi_pin_sync.sv | 35 +++
 rtl/spi_reg_peripheral.sv | 144 ++++++++++++++
 tb/tb_spi_reg_peripheral.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register peripheral: frame size, register map and FSM encoding.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  // Register map as seen by the SPI controller
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle: the controller drives all three lines, the peripheral only listens.
interface spi_reg_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  // RST_VAL lets idle-high pins (ncs) come out of reset without a false edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain to one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 peripheral: receives {R/W, addr, data} frames and updates the
// five config registers consumed by pwm_peripheral.
module spi_reg_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_reg_peripheral_if.slave  spi,
  output logic [DATA_W-1:0]    en_reg_out_7_0,
  output logic [DATA_W-1:0]    en_reg_out_15_8,
  output logic [DATA_W-1:0]    en_reg_pwm_7_0,
  output logic [DATA_W-1:0]    en_reg_pwm_15_8,
  output logic [DATA_W-1:0]    pwm_duty_cycle,
  output logic                 wr_strobe,
  output logic                 frame_err
);

  import spi_reg_pkg::*;

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_REGS);

  // Synchronized pins and edges
  logic sclk_rise;
  logic sclk_lvl_unused, sclk_fall_unused;
  logic ncs_sync, ncs_rise, ncs_fall;
  logic copi_sync;
  logic copi_rise_unused, copi_fall_unused;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (spi.sclk),
    .sync  (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (spi.ncs),
    .sync  (ncs_sync),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (spi.copi),
    .sync  (copi_sync),
    .rise  (copi_rise_unused),
    .fall  (copi_fall_unused)
  );

  logic [1:0]            state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];

  // Frame fields, valid once the full frame has been shifted in
  logic              frame_wr;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              commit_wr;
  logic              commit_err;

  assign frame_wr   = shift_q[FRAME_BITS-1];
  assign frame_addr = shift_q[DATA_W +: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    commit_wr  = 1'b0;
    commit_err = 1'b0;
    if (state_q == ST_COMMIT) begin
      if (cnt_q != CNT_FULL) begin
        commit_err = 1'b1;
      end else if (frame_wr && (frame_addr < ADDR_LIM)) begin
        commit_wr = 1'b1;
      end
    end
  end

  // Shifting stops while ncs is (synced) high, so an sclk edge coincident with either ncs
  // edge is dropped: ncs_sync is high on a rise, and the state is still IDLE on a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= commit_wr;
      frame_err <= commit_err;
      case (state_q)
        ST_IDLE: begin
          if (ncs_fall) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (ncs_rise) begin
            state_q <= ST_COMMIT;
          end else if (sclk_rise && !ncs_sync) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_sync};
            if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the register file drives pwm_peripheral directly and must read 0x00 after reset,
  // so this small memory is reset like ordinary flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_wr && (frame_addr == ADDR_W'(i))) regs_q[i] <= frame_data;
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[int'(ADDR_EN_OUT_7_0)];
  assign en_reg_out_15_8 = regs_q[int'(ADDR_EN_OUT_15_8)];
  assign en_reg_pwm_7_0  = regs_q[int'(ADDR_EN_PWM_7_0)];
  assign en_reg_pwm_15_8 = regs_q[int'(ADDR_EN_PWM_15_8)];
  assign pwm_duty_cycle  = regs_q[int'(ADDR_PWM_DUTY)];

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Scoreboard bench for spi_reg_peripheral: directed SPI frames push expected events,
// a negedge monitor pops and compares whenever wr_strobe or frame_err fires.
module tb_spi_reg_peripheral;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe, frame_err;

  spi_reg_peripheral_if spi ();

  spi_reg_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi             (spi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic [1:0] {EV_WR = 2'b10, EV_ERR = 2'b01} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          due;
    logic [39:0] regs;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model [5];
  logic [39:0] prev_regs;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] dut_regs();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  function automatic logic [39:0] model_regs();
    return {model[0], model[1], model[2], model[3], model[4]};
  endfunction

  // Monitor: every strobe/error pulse must match the head of the queue, on time.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_regs = dut_regs();
    end else begin
      if (wr_strobe || frame_err) begin
        if (exp_q.size() == 0) begin
          check("stray_event", {62'd0, wr_strobe, frame_err}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", {62'd0, wr_strobe, frame_err}, {62'd0, mon_e.kind});
          check("event_latency", cyc, mon_e.due);
          check("event_regs", dut_regs(), mon_e.regs);
        end
      end else if (dut_regs() != prev_regs) begin
        check("reg_change_without_strobe", dut_regs(), prev_regs);
      end
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("missed_event", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      prev_regs = dut_regs();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One mode-0 bit: data set with sclk low, sampled on rise; phases at minimum width (3 clk).
  task automatic bit_out(input logic b);
    spi.sclk = 1'b0;
    spi.copi = b;
    tick(3);
    spi.sclk = 1'b1;
    tick(3);
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    logic [31:0] v;
    v = bits;
    spi.ncs = 1'b0;
    for (int i = n - 1; i >= 0; i--) bit_out(v[i]);
    spi.sclk = 1'b0;
    tick(3);
    spi.ncs = 1'b1;
  endtask

  // Each frame helper ends with ncs high for 4 clk, the minimum inter-frame gap.
  task automatic frame_wr(input logic [31:0] bits, input int addr, input logic [7:0] data);
    exp_t e;
    send(bits, 16);
    model[addr] = data;
    e.kind = EV_WR;
    e.due  = cyc + 4;
    e.regs = model_regs();
    exp_q.push_back(e);
    tick(4);
  endtask

  task automatic frame_bad(input logic [31:0] bits, input int n);
    exp_t e;
    send(bits, n);
    e.kind = EV_ERR;
    e.due  = cyc + 4;
    e.regs = model_regs();
    exp_q.push_back(e);
    tick(4);
  endtask

  task automatic frame_quiet(input logic [31:0] bits);
    send(bits, 16);
    tick(4);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    rst_n    = 1'b0;
    tick(3);
    check("reset_regs", dut_regs(), 40'h0);
    check("reset_flags", {62'd0, wr_strobe, frame_err}, 64'd0);
    rst_n = 1'b1;
    tick(3);

    // Basic write to addr 0
    frame_wr(32'h80F0, 0, 8'hF0);
    check("after_write_0", dut_regs(), 40'hF0_00_00_00_00);

    // Read request and out-of-range address: silently ignored
    frame_quiet(32'h00FF);
    frame_quiet(32'h85AA);
    check("after_ignored", dut_regs(), 40'hF0_00_00_00_00);

    // Short and long frames
    frame_bad(32'h4240, 15);
    frame_bad(32'h10901, 17);
    check("after_bad_frames", dut_regs(), 40'hF0_00_00_00_00);

    // Reset in the middle of a frame
    spi.ncs = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] b;
      b = 8'h84;
      bit_out(b[i]);
    end
    rst_n    = 1'b0;
    spi.sclk = 1'b0;
    spi.ncs  = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    check("midframe_reset_regs", dut_regs(), 40'h0);
    check("midframe_reset_flags", {62'd0, wr_strobe, frame_err}, 64'd0);
    rst_n = 1'b1;
    tick(4);
    check("after_reset_idle", dut_regs(), 40'h0);
    frame_wr(32'h8480, 4, 8'h80);
    check("after_duty_write", dut_regs(), 40'h00_00_00_00_80);

    // Back-to-back frames at minimum gap
    frame_wr(32'h81FF, 1, 8'hFF);
    frame_wr(32'h8255, 2, 8'h55);
    frame_wr(32'h83AA, 3, 8'hAA);
    check("after_back_to_back", dut_regs(), 40'h00_FF_55_AA_80);

    // sclk activity with ncs deasserted must not disturb anything
    for (int i = 0; i < 4; i++) begin
      spi.sclk = 1'b1;
      spi.copi = ~spi.copi;
      tick(3);
      spi.sclk = 1'b0;
      tick(3);
    end
    check("after_idle_sclk", dut_regs(), 40'h00_FF_55_AA_80);
    frame_wr(32'h8433, 4, 8'h33);

    tick(10);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_en_out_7_0", {56'd0, en_reg_out_7_0}, 64'h00);
    check("final_en_out_15_8", {56'd0, en_reg_out_15_8}, 64'hFF);
    check("final_en_pwm_7_0", {56'd0, en_reg_pwm_7_0}, 64'h55);
    check("final_en_pwm_15_8", {56'd0, en_reg_pwm_15_8}, 64'hAA);
    check("final_duty", {56'd0, pwm_duty_cycle}, 64'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
